// File: rtl/salida_parqueo_if.sv
// -----------------------------------------------------------------------------
// salida_parqueo_if
// Signal bundle between the exit-lane sensors/keypad and the exit controller.
//   master : environment side (drives sensors and keypad, reads gate/alarms)
//   slave  : controller side (reads sensors and keypad, drives gate/alarms)
// Signals:
//   sensor_llegada_salida  vehicle present on the exit loop, before the gate
//   sensor_paso_salida     vehicle under / past the gate
//   clave_ingresada [7:0]  keypad PIN, qualified by clave_valida
//   clave_valida           one-cycle strobe for clave_ingresada
//   senal_compuerta        1 = gate open
//   senal_alarma_pin       1 = too many wrong PINs
//   senal_alarma_bloqueo   1 = gate locked (tailgate / wrong-way)
//   intentos [3:0]         wrong-PIN count, saturating
//   vehiculo_salio         one-cycle pulse per completed exit
// -----------------------------------------------------------------------------
interface salida_parqueo_if;
    logic       sensor_llegada_salida;
    logic       sensor_paso_salida;
    logic [7:0] clave_ingresada;
    logic       clave_valida;
    logic       senal_compuerta;
    logic       senal_alarma_pin;
    logic       senal_alarma_bloqueo;
    logic [3:0] intentos;
    logic       vehiculo_salio;

    modport master (
        output sensor_llegada_salida,
        output sensor_paso_salida,
        output clave_ingresada,
        output clave_valida,
        input  senal_compuerta,
        input  senal_alarma_pin,
        input  senal_alarma_bloqueo,
        input  intentos,
        input  vehiculo_salio
    );

    modport slave (
        input  sensor_llegada_salida,
        input  sensor_paso_salida,
        input  clave_ingresada,
        input  clave_valida,
        output senal_compuerta,
        output senal_alarma_pin,
        output senal_alarma_bloqueo,
        output intentos,
        output vehiculo_salio
    );
endinterface

// File: rtl/salida_parqueo.sv
// -----------------------------------------------------------------------------
// salida_parqueo
// Exit-lane gate controller. Detects a vehicle on the exit loop, checks an
// 8-bit exit PIN, opens the gate, follows the vehicle through it and closes
// the gate again. Raises a PIN alarm after repeated wrong PINs and a lock
// alarm on tailgating or wrong-way detection.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   bus    salida_parqueo_if.slave (sensors, keypad, gate and alarm outputs)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module salida_parqueo #(
    parameter logic [7:0] CLAVE_CORRECTA   = 8'hA5,
    parameter int         MAX_INTENTOS     = 3,
    parameter int         TIEMPO_COMPUERTA = 1000,
    parameter int         ANCHO_TIEMPO     = 16
) (
    input  logic             clock,
    input  logic             reset,
    salida_parqueo_if.slave  bus
);

    // One-hot state encoding
    localparam logic [4:0] ESPERA      = 5'b00001;
    localparam logic [4:0] VERIFICANDO = 5'b00010;
    localparam logic [4:0] SALIENDO    = 5'b00100;
    localparam logic [4:0] CERRANDO    = 5'b01000;
    localparam logic [4:0] BLOQUEO     = 5'b10000;

    localparam logic [3:0]              MAX_I      = 4'(MAX_INTENTOS);
    localparam logic [ANCHO_TIEMPO-1:0] TIMER_LAST = ANCHO_TIEMPO'(TIEMPO_COMPUERTA - 1);

    logic [4:0]              state_reg, state_next;
    logic [ANCHO_TIEMPO-1:0] timer_reg, timer_next;
    logic [3:0]              intentos_reg, intentos_next;
    logic                    compuerta_reg, compuerta_next;
    logic                    alarma_pin_reg, alarma_pin_next;
    logic                    alarma_bloqueo_reg, alarma_bloqueo_next;
    logic                    salio_reg, salio_next;
    // Set once the exit loop has been seen empty while the vehicle is
    // passing; a later rising llegada means a second vehicle is following.
    logic                    visto_bajo_reg, visto_bajo_next;

    logic llegada;
    logic paso;
    logic clave_ok;

    assign llegada  = bus.sensor_llegada_salida;
    assign paso     = bus.sensor_paso_salida;
    assign clave_ok = bus.clave_valida && (bus.clave_ingresada == CLAVE_CORRECTA);

    always_comb begin
        state_next          = state_reg;
        timer_next          = timer_reg;
        intentos_next       = intentos_reg;
        compuerta_next      = compuerta_reg;
        alarma_pin_next     = alarma_pin_reg;
        alarma_bloqueo_next = alarma_bloqueo_reg;
        visto_bajo_next     = visto_bajo_reg;
        salio_next          = 1'b0;

        case (state_reg)
            ESPERA: begin
                // Keypad is ignored until a vehicle is on the loop.
                if (llegada && paso) begin
                    state_next          = BLOQUEO;
                    compuerta_next      = 1'b0;
                    alarma_bloqueo_next = 1'b1;
                end else if (llegada) begin
                    state_next = VERIFICANDO;
                end
            end

            VERIFICANDO: begin
                // Lock wins over a key strobe in the same cycle; a vehicle
                // backing out wins over the key as well.
                if (llegada && paso) begin
                    state_next          = BLOQUEO;
                    compuerta_next      = 1'b0;
                    alarma_bloqueo_next = 1'b1;
                end else if (!llegada) begin
                    state_next      = ESPERA;
                    intentos_next   = 4'd0;
                    alarma_pin_next = 1'b0;
                end else if (clave_ok) begin
                    state_next      = SALIENDO;
                    compuerta_next  = 1'b1;
                    intentos_next   = 4'd0;
                    alarma_pin_next = 1'b0;
                    timer_next      = '0;
                end else if (bus.clave_valida) begin
                    if (intentos_reg < MAX_I) begin
                        intentos_next = intentos_reg + 4'd1;
                    end
                    alarma_pin_next = (intentos_next >= MAX_I);
                end
            end

            SALIENDO: begin
                // A vehicle reaching the gate on the last open cycle still
                // gets through; the timer never counts past TIMER_LAST.
                if (paso) begin
                    state_next      = CERRANDO;
                    visto_bajo_next = 1'b0;
                end else if (timer_reg == TIMER_LAST) begin
                    compuerta_next = 1'b0;
                    state_next     = llegada ? VERIFICANDO : ESPERA;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            CERRANDO: begin
                if (visto_bajo_reg && llegada) begin
                    state_next          = BLOQUEO;
                    compuerta_next      = 1'b0;
                    alarma_bloqueo_next = 1'b1;
                end else if (!llegada && !paso) begin
                    state_next     = ESPERA;
                    compuerta_next = 1'b0;
                    salio_next     = 1'b1;
                end else if (!llegada) begin
                    visto_bajo_next = 1'b1;
                end
            end

            BLOQUEO: begin
                // Only a correct key with the lane fully clear unlocks;
                // wrong keys are not counted here.
                if (clave_ok && !llegada && !paso) begin
                    state_next          = ESPERA;
                    alarma_bloqueo_next = 1'b0;
                    intentos_next       = 4'd0;
                    alarma_pin_next     = 1'b0;
                end
            end

            default: begin
                // Corrupted encoding: recover to a safe, closed gate.
                state_next          = ESPERA;
                timer_next          = '0;
                intentos_next       = 4'd0;
                compuerta_next      = 1'b0;
                alarma_pin_next     = 1'b0;
                alarma_bloqueo_next = 1'b0;
                visto_bajo_next     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg          <= ESPERA;
            timer_reg          <= '0;
            intentos_reg       <= 4'd0;
            compuerta_reg      <= 1'b0;
            alarma_pin_reg     <= 1'b0;
            alarma_bloqueo_reg <= 1'b0;
            salio_reg          <= 1'b0;
            visto_bajo_reg     <= 1'b0;
        end else begin
            state_reg          <= state_next;
            timer_reg          <= timer_next;
            intentos_reg       <= intentos_next;
            compuerta_reg      <= compuerta_next;
            alarma_pin_reg     <= alarma_pin_next;
            alarma_bloqueo_reg <= alarma_bloqueo_next;
            salio_reg          <= salio_next;
            visto_bajo_reg     <= visto_bajo_next;
        end
    end

    assign bus.senal_compuerta      = compuerta_reg;
    assign bus.senal_alarma_pin     = alarma_pin_reg;
    assign bus.senal_alarma_bloqueo = alarma_bloqueo_reg;
    assign bus.intentos             = intentos_reg;
    assign bus.vehiculo_salio       = salio_reg;

endmodule

// File: tb/tb_salida_parqueo.sv
// -----------------------------------------------------------------------------
// tb_salida_parqueo
// Self-checking bench for salida_parqueo (gate-open time shortened to 8).
// Directed scenarios use tables of expected output vectors; a randomized run
// is compared cycle by cycle with a behavioural model of the exit lane.
// Output vector layout: {compuerta, alarma_pin, alarma_bloqueo, intentos[3:0], salio}
// -----------------------------------------------------------------------------
module tb_salida_parqueo;

    localparam int         T_GATE = 8;
    localparam int         MAXI   = 3;
    localparam logic [7:0] K_OK   = 8'hA5;
    localparam logic [7:0] K_BAD  = 8'h00;

    logic clock = 1'b0;
    logic reset = 1'b0;

    salida_parqueo_if bus ();

    salida_parqueo #(
        .CLAVE_CORRECTA  (8'hA5),
        .MAX_INTENTOS    (MAXI),
        .TIEMPO_COMPUERTA(T_GATE),
        .ANCHO_TIEMPO    (16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] obs;
    assign obs = {bus.senal_compuerta, bus.senal_alarma_pin, bus.senal_alarma_bloqueo,
                  bus.intentos, bus.vehiculo_salio};

    typedef struct packed {
        logic       ll;
        logic       pa;
        logic [7:0] key;
        logic       v;
        logic [7:0] exp;
    } row_t;

    function automatic logic [7:0] pk(input logic g, input logic ap, input logic al,
                                      input logic [3:0] t, input logic s);
        return {g, ap, al, t, s};
    endfunction

    // ---------------- behavioural model of the exit lane ----------------
    // Phases: 0 idle, 1 waiting for PIN, 2 gate open, 3 vehicle passing, 4 locked
    int m_phase, m_tries, m_left;
    bit m_gate, m_apin, m_alock, m_pulse, m_seen_low;

    task automatic model_reset();
        m_phase = 0; m_tries = 0; m_left = 0;
        m_gate = 0; m_apin = 0; m_alock = 0; m_pulse = 0; m_seen_low = 0;
    endtask

    task automatic model_step(input logic ll, input logic pa, input logic [7:0] key, input logic v);
        bit ok;
        ok = v && (key == K_OK);
        m_pulse = 0;
        if (m_phase == 0) begin
            if (ll && pa) begin m_phase = 4; m_alock = 1; m_gate = 0; end
            else if (ll) m_phase = 1;
        end else if (m_phase == 1) begin
            if (ll && pa) begin m_phase = 4; m_alock = 1; m_gate = 0; end
            else if (!ll) begin m_phase = 0; m_tries = 0; m_apin = 0; end
            else if (ok) begin m_phase = 2; m_gate = 1; m_tries = 0; m_apin = 0; m_left = T_GATE; end
            else if (v) begin
                m_tries = (m_tries + 1 > MAXI) ? MAXI : m_tries + 1;
                m_apin  = (m_tries == MAXI);
            end
        end else if (m_phase == 2) begin
            if (pa) begin m_phase = 3; m_seen_low = 0; end
            else begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_gate = 0; m_phase = ll ? 1 : 0; end
            end
        end else if (m_phase == 3) begin
            if (m_seen_low && ll) begin m_phase = 4; m_gate = 0; m_alock = 1; end
            else if (!ll && !pa) begin m_phase = 0; m_gate = 0; m_pulse = 1; end
            else if (!ll) m_seen_low = 1;
        end else begin
            if (ok && !ll && !pa) begin m_phase = 0; m_alock = 0; m_tries = 0; m_apin = 0; end
        end
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic step(input logic ll, input logic pa, input logic [7:0] key, input logic v);
        bus.sensor_llegada_salida = ll;
        bus.sensor_paso_salida    = pa;
        bus.clave_ingresada       = key;
        bus.clave_valida          = v;
        @(posedge clock);
        model_step(ll, pa, key, v);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.sensor_llegada_salida = 1'b0;
        bus.sensor_paso_salida    = 1'b0;
        bus.clave_ingresada       = 8'h00;
        bus.clave_valida          = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.sensor_llegada_salida = 1'b1;
        bus.sensor_paso_salida    = 1'b1;
        bus.clave_ingresada       = K_OK;
        bus.clave_valida          = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if (obs !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_held: got %b want %b", obs, 8'h00);
        end
        do_reset();
        tests_run++;
        if (obs !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_released: got %b want %b", obs, 8'h00);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_normal_exit();
        row_t rows [9];
        rows = '{
            '{1'b1, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, K_OK,  1'b1, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b1, K_BAD, 1'b0, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b0, 1'b1, K_BAD, 1'b0, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b0, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b1)},
            '{1'b0, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b0, 1'b0, K_OK,  1'b1, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, K_OK,  1'b1, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)}
        };
        do_reset();
        foreach (rows[i]) begin
            step(rows[i].ll, rows[i].pa, rows[i].key, rows[i].v);
            tests_run++;
            if (obs !== rows[i].exp) begin
                tests_failed++;
                $display("FAIL normal_exit[%0d]: got %b want %b", i, obs, rows[i].exp);
            end
        end
        $display("[TB] test_normal_exit done");
    endtask

    task automatic test_pin_alarm();
        row_t rows [6];
        rows = '{
            '{1'b1, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, K_BAD, 1'b1, pk(1'b0, 1'b0, 1'b0, 4'd1, 1'b0)},
            '{1'b1, 1'b0, K_BAD, 1'b1, pk(1'b0, 1'b0, 1'b0, 4'd2, 1'b0)},
            '{1'b1, 1'b0, K_BAD, 1'b1, pk(1'b0, 1'b1, 1'b0, 4'd3, 1'b0)},
            '{1'b1, 1'b0, K_BAD, 1'b1, pk(1'b0, 1'b1, 1'b0, 4'd3, 1'b0)},
            '{1'b1, 1'b0, K_OK,  1'b1, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)}
        };
        do_reset();
        foreach (rows[i]) begin
            step(rows[i].ll, rows[i].pa, rows[i].key, rows[i].v);
            tests_run++;
            if (obs !== rows[i].exp) begin
                tests_failed++;
                $display("FAIL pin_alarm[%0d]: got %b want %b", i, obs, rows[i].exp);
            end
        end
        $display("[TB] test_pin_alarm done");
    endtask

    task automatic test_back_out();
        row_t rows [8];
        rows = '{
            '{1'b1, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, K_BAD, 1'b1, pk(1'b0, 1'b0, 1'b0, 4'd1, 1'b0)},
            '{1'b1, 1'b0, 8'h5A, 1'b1, pk(1'b0, 1'b0, 1'b0, 4'd2, 1'b0)},
            '{1'b0, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b0, 1'b1, K_OK,  1'b1, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, 8'hA4, 1'b1, pk(1'b0, 1'b0, 1'b0, 4'd1, 1'b0)},
            '{1'b1, 1'b0, K_OK,  1'b0, pk(1'b0, 1'b0, 1'b0, 4'd1, 1'b0)}
        };
        do_reset();
        foreach (rows[i]) begin
            step(rows[i].ll, rows[i].pa, rows[i].key, rows[i].v);
            tests_run++;
            if (obs !== rows[i].exp) begin
                tests_failed++;
                $display("FAIL back_out[%0d]: got %b want %b", i, obs, rows[i].exp);
            end
        end
        $display("[TB] test_back_out done");
    endtask

    task automatic test_lock();
        row_t rows [8];
        rows = '{
            '{1'b1, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b1, K_OK,  1'b1, pk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0)},
            '{1'b1, 1'b1, K_OK,  1'b1, pk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0)},
            '{1'b0, 1'b1, K_OK,  1'b1, pk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0)},
            '{1'b0, 1'b0, K_BAD, 1'b1, pk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0)},
            '{1'b0, 1'b0, K_OK,  1'b1, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, K_OK,  1'b1, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)}
        };
        do_reset();
        foreach (rows[i]) begin
            step(rows[i].ll, rows[i].pa, rows[i].key, rows[i].v);
            tests_run++;
            if (obs !== rows[i].exp) begin
                tests_failed++;
                $display("FAIL lock[%0d]: got %b want %b", i, obs, rows[i].exp);
            end
        end
        $display("[TB] test_lock done");
    endtask

    // Gate held open for T_GATE cycles with nobody passing, then reopened;
    // on the second opening the vehicle reaches the gate on the last cycle.
    task automatic test_timeout();
        logic exp_gate;
        do_reset();
        step(1'b1, 1'b0, K_BAD, 1'b0);
        for (int round = 0; round < 2; round++) begin
            step(1'b1, 1'b0, K_OK, 1'b1);
            tests_run++;
            if (obs !== pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)) begin
                tests_failed++;
                $display("FAIL timeout_open[%0d]: got %b want %b", round, obs,
                         pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
            end
            for (int c = 1; c <= T_GATE; c++) begin
                // round 1: paso arrives on the final open cycle and must win
                step(1'b1, (round == 1 && c == T_GATE), K_BAD, 1'b0);
                exp_gate = (c < T_GATE) || (round == 1);
                tests_run++;
                if (bus.senal_compuerta !== exp_gate) begin
                    tests_failed++;
                    $display("FAIL timeout_gate[r%0d c%0d]: got %b want %b", round, c,
                             bus.senal_compuerta, exp_gate);
                end
            end
        end
        step(1'b0, 1'b0, K_BAD, 1'b0);
        tests_run++;
        if (obs !== pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b1)) begin
            tests_failed++;
            $display("FAIL timeout_late_pass: got %b want %b", obs, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
        end
        $display("[TB] test_timeout done");
    endtask

    task automatic test_tailgate();
        row_t rows [7];
        rows = '{
            '{1'b1, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b0, K_OK,  1'b1, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b1, K_BAD, 1'b0, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b0, 1'b1, K_BAD, 1'b0, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)},
            '{1'b1, 1'b1, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0)},
            '{1'b0, 1'b0, K_BAD, 1'b0, pk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0)},
            '{1'b0, 1'b0, K_OK,  1'b1, pk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0)}
        };
        do_reset();
        foreach (rows[i]) begin
            step(rows[i].ll, rows[i].pa, rows[i].key, rows[i].v);
            tests_run++;
            if (obs !== rows[i].exp) begin
                tests_failed++;
                $display("FAIL tailgate[%0d]: got %b want %b", i, obs, rows[i].exp);
            end
        end
        $display("[TB] test_tailgate done");
    endtask

    task automatic test_async_reset();
        do_reset();
        // Raise the PIN alarm, then reset between edges.
        step(1'b1, 1'b0, K_BAD, 1'b0);
        repeat (3) step(1'b1, 1'b0, K_BAD, 1'b1);
        step(1'b1, 1'b0, K_BAD, 1'b0);
        tests_run++;
        if (obs !== pk(1'b0, 1'b1, 1'b0, 4'd3, 1'b0)) begin
            tests_failed++;
            $display("FAIL async_pre_alarm: got %b want %b", obs, pk(1'b0, 1'b1, 1'b0, 4'd3, 1'b0));
        end
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (obs !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_clear_alarm: got %b want %b", obs, 8'h00);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
        // Open the gate, reset mid-SALIENDO.
        step(1'b1, 1'b0, K_BAD, 1'b0);
        step(1'b1, 1'b0, K_OK, 1'b1);
        step(1'b1, 1'b0, K_BAD, 1'b0);
        tests_run++;
        if (bus.senal_compuerta !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre_open: got %b want 1", bus.senal_compuerta);
        end
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (obs !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_clear_gate: got %b want %b", obs, 8'h00);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
        bus.sensor_llegada_salida = 1'b0;
        bus.sensor_paso_salida    = 1'b0;
        step(1'b0, 1'b0, K_OK, 1'b1);
        tests_run++;
        if (obs !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_key_ignored: got %b want %b", obs, 8'h00);
        end
        step(1'b1, 1'b0, K_BAD, 1'b0);
        step(1'b1, 1'b0, K_OK, 1'b1);
        tests_run++;
        if (obs !== pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)) begin
            tests_failed++;
            $display("FAIL async_reopen: got %b want %b", obs, pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
        end
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_random();
        logic       ll, pa, v;
        logic [7:0] key, exp;
        int         errs;
        errs = 0;
        do_reset();
        ll = 1'b0;
        pa = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) < 15) ll = ~ll;
            if ($urandom_range(99) < 20) pa = ~pa;
            v   = ($urandom_range(99) < 35);
            key = ($urandom_range(1) == 0) ? K_OK : 8'($urandom);
            step(ll, pa, key, v);
            exp = pk(m_gate, m_apin, m_alock, 4'(m_tries), m_pulse);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got %b want %b (ll=%b pa=%b key=%h v=%b)",
                             n, obs, exp, ll, pa, key, v);
            end
        end
        $display("[TB] test_random done, %0d cycles", 3000);
    endtask

    initial begin
        bus.sensor_llegada_salida = 1'b0;
        bus.sensor_paso_salida    = 1'b0;
        bus.clave_ingresada       = 8'h00;
        bus.clave_valida          = 1'b0;
        model_reset();
        test_reset();
        test_normal_exit();
        test_pin_alarm();
        test_back_out();
        test_lock();
        test_timeout();
        test_tailgate();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
